// File: rtl/mem_access_unit.sv
// Sub-word load/store adapter between EX/MEM and a word-only, synchronous-read DataMemory.
// Loads take one extra cycle for the read; sb/sh do a read-modify-write over two cycles.
module mem_access_unit #(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  MemSize,
  input  logic        MemUnsigned,
  input  logic [31:0] ALUResult,
  input  logic [31:0] StoreData,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] LoadData,
  output logic        load_valid,
  output logic        stall,
  output logic        misaligned,
  output logic [31:0] BadAddr
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RMW} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_uns;

  logic w_req;
  logic w_is_word;
  logic w_is_half;
  logic w_mis;

  function automatic logic [1:0] byte_lane(input logic [1:0] a);
    return BIG_ENDIAN ? ~a : a;
  endfunction

  function automatic logic half_lane(input logic a1);
    return BIG_ENDIAN ? ~a1 : a1;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] a,
                                               input logic [1:0] sz, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = word[{byte_lane(a), 3'b000} +: 8];
    h = word[{half_lane(a[1]), 4'b0000} +: 16];
    case (sz)
      2'b00:   return uns ? {24'd0, b} : 32'(b);
      2'b01:   return uns ? {16'd0, h} : 32'(h);
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [1:0] a,
                                              input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] out;
    out = word;
    case (sz)
      2'b00:   out[{byte_lane(a), 3'b000} +: 8]  = d[7:0];
      2'b01:   out[{half_lane(a[1]), 4'b0000} +: 16] = d[15:0];
      default: out = d;
    endcase
    return out;
  endfunction

  // MemSize 11 behaves exactly like a word access, alignment check included
  assign w_req     = MemRead | MemWrite;
  assign w_is_word = MemSize[1];
  assign w_is_half = (MemSize == 2'b01);
  assign w_mis     = w_req & ((w_is_half & ALUResult[0]) | (w_is_word & (|ALUResult[1:0])));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_mis) begin
          if (MemWrite && !w_is_word) w_next = S_RMW;
          else if (MemRead && !MemWrite) w_next = S_LOAD;
        end
      end
      S_LOAD:  w_next = S_IDLE;
      S_RMW:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = ALUResult;
    mem_we    = 1'b0;
    mem_wdata = StoreData;
    stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_mis) begin
          if (MemWrite) begin
            if (w_is_word) mem_we = 1'b1;
            else           stall  = 1'b1;
          end else if (MemRead) begin
            stall = 1'b1;
          end
        end
      end
      S_LOAD: mem_addr = r_addr;
      S_RMW: begin
        mem_addr  = {r_addr[31:2], 2'b00};
        mem_we    = 1'b1;
        mem_wdata = store_merge(mem_rdata, r_addr[1:0], r_size, r_wdata);
      end
      default: ;
    endcase
    // reset aborts any in-flight write and releases the pipeline immediately
    if (reset) begin
      mem_we = 1'b0;
      stall  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_next != S_IDLE) begin
      r_addr  <= ALUResult;
      r_size  <= MemSize;
      r_uns   <= MemUnsigned;
      r_wdata <= StoreData;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      LoadData   <= 32'd0;
      load_valid <= 1'b0;
      misaligned <= 1'b0;
      BadAddr    <= 32'd0;
    end else begin
      load_valid <= (r_state == S_LOAD);
      if (r_state == S_LOAD) LoadData <= load_extract(mem_rdata, r_addr[1:0], r_size, r_uns);
      misaligned <= (r_state == S_IDLE) && w_mis;
      if (r_state == S_IDLE && w_mis) BadAddr <= ALUResult;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus random traffic against a transaction-level model.
module tb_mem_access_unit;
  localparam bit BE = 1'b0;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, MemUnsigned;
  logic [1:0]  MemSize;
  logic [31:0] ALUResult, StoreData;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [31:0] LoadData, BadAddr;
  logic        load_valid, stall, misaligned;

  logic [31:0] dmem    [64];
  logic [31:0] ref_mem [64];
  logic [31:0] exp_ld  = 32'd0;
  logic [31:0] exp_bad = 32'd0;
  int          n_cmp = 0;
  int          n_bad = 0;

  mem_access_unit #(.BIG_ENDIAN(BE)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize),
    .MemUnsigned(MemUnsigned), .ALUResult(ALUResult), .StoreData(StoreData),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .LoadData(LoadData), .load_valid(load_valid), .stall(stall), .misaligned(misaligned),
    .BadAddr(BadAddr)
  );

  always #5 clk = ~clk;

  // word-only DataMemory with synchronous read
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr[7:2]] <= mem_wdata;
    mem_rdata <= dmem[mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int unsigned lane_shift(input logic [1:0] a, input logic [1:0] sz);
    int unsigned ai;
    ai = a;
    if (sz == 2'b00) return BE ? (3 - ai) * 8 : ai * 8;
    if (sz == 2'b01) return BE ? (2 - ai) * 8 : ai * 8;
    return 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [1:0] a,
                                           input logic [1:0] sz, input logic uns);
    int unsigned w, v;
    if (sz[1]) return word;
    w = (sz == 2'b00) ? 8 : 16;
    v = (word >> lane_shift(a, sz)) & ((32'd1 << w) - 1);
    if (!uns && v >= (32'd1 << (w - 1))) v = v - (32'd1 << w);
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input logic [1:0] a,
                                            input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] mask;
    int unsigned sh;
    if (sz[1]) return d;
    sh   = lane_shift(a, sz);
    mask = (sz == 2'b00 ? 32'hFF : 32'hFFFF) << sh;
    return (word & ~mask) | ((d << sh) & mask);
  endfunction

  task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] d);
    MemRead = rd; MemWrite = wr; MemSize = sz; MemUnsigned = uns; ALUResult = a; StoreData = d;
  endtask

  // Called just after a falling edge; returns just after the falling edge that ends the operation.
  task automatic op(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                    input logic [31:0] a, input logic [31:0] d);
    logic mis, is_ld, sub, sw;
    logic [31:0] nw;
    mis   = (rd | wr) && ((sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00));
    is_ld = rd && !wr && !mis;
    sub   = wr && !sz[1] && !mis;
    sw    = wr && sz[1] && !mis;
    drive(rd, wr, sz, uns, a, d);
    #1;
    chk("c0_stall", stall, sub || is_ld);
    chk("c0_we", mem_we, sw);
    chk("c0_addr", mem_addr, a);
    if (sw) begin
      chk("sw_wdata", mem_wdata, d);
      ref_mem[a[7:2]] = d;
    end
    @(negedge clk);
    if (!(sub || is_ld)) begin
      if (mis) exp_bad = a;
      chk("mis_pulse", misaligned, mis);
      chk("bad_addr", BadAddr, exp_bad);
      chk("no_lv", load_valid, 1'b0);
      chk("ld_hold", LoadData, exp_ld);
    end else begin
      #1;
      chk("c1_stall", stall, 1'b0);
      chk("c1_we", mem_we, sub);
      chk("c1_waddr", mem_addr >> 2, a >> 2);
      chk("c1_mis", misaligned, 1'b0);
      if (sub) begin
        nw = ref_store(ref_mem[a[7:2]], a[1:0], sz, d);
        chk("rmw_wdata", mem_wdata, nw);
        ref_mem[a[7:2]] = nw;
      end else begin
        exp_ld = ref_load(ref_mem[a[7:2]], a[1:0], sz, uns);
      end
      @(negedge clk);
      chk("lv", load_valid, is_ld);
      chk("ld_data", LoadData, exp_ld);
    end
  endtask

  // Starts an aligned load or sub-word store and hits it with reset in its second cycle.
  task automatic abort_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] d);
    drive(rd, wr, sz, 1'b0, a, d);
    #1;
    chk("ab_c0_stall", stall, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ab_we", mem_we, 1'b0);
    chk("ab_stall", stall, 1'b0);
    @(negedge clk);
    reset   = 1'b0;
    exp_ld  = 32'd0;
    exp_bad = 32'd0;
    chk("ab_lv", load_valid, 1'b0);
    chk("ab_ld", LoadData, 32'd0);
  endtask

  initial begin
    logic [31:0] v, a;
    logic [1:0]  sz;
    for (int i = 0; i < 64; i++) begin
      v = $urandom;
      dmem[i] = v;
      ref_mem[i] = v;
    end
    dmem[16] = 32'h8899AABB;
    ref_mem[16] = 32'h8899AABB;

    reset = 1'b1;
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF);
    #1;
    chk("rst_we", mem_we, 1'b0);
    chk("rst_stall", stall, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_ld", LoadData, 32'd0);
    chk("rst_bad", BadAddr, 32'd0);
    chk("rst_lv", load_valid, 1'b0);
    chk("rst_mis", misaligned, 1'b0);
    reset = 1'b0;

    op(1, 0, 2'b00, 0, 32'h41, 0);
    op(1, 0, 2'b00, 1, 32'h41, 0);
    op(1, 0, 2'b01, 0, 32'h42, 0);
    op(1, 0, 2'b01, 1, 32'h42, 0);
    op(1, 0, 2'b10, 0, 32'h40, 0);
    op(0, 1, 2'b00, 0, 32'h43, 32'h12345677);
    op(1, 0, 2'b10, 0, 32'h40, 0);
    chk("sb_word", exp_ld, 32'h7799AABB);
    op(0, 1, 2'b01, 0, 32'h40, 32'h0000CAFE);
    op(1, 0, 2'b10, 0, 32'h40, 0);
    chk("sh_word", exp_ld, 32'h7799CAFE);
    op(0, 1, 2'b10, 0, 32'h42, 32'h55555555);
    op(1, 0, 2'b01, 0, 32'h41, 0);
    op(1, 0, 2'b10, 0, 32'h40, 0);
    op(0, 1, 2'b10, 0, 32'h40, 32'h01020304);
    op(1, 0, 2'b10, 0, 32'h40, 0);
    op(1, 1, 2'b10, 0, 32'h44, 32'hA5A5F00D);
    op(1, 0, 2'b10, 0, 32'h44, 0);
    op(0, 1, 2'b11, 0, 32'h48, 32'h0BADF00D);
    op(1, 0, 2'b11, 0, 32'h4A, 0);
    op(1, 0, 2'b11, 0, 32'h48, 0);
    op(0, 1, 2'b10, 0, 32'h4C, 32'h11111111);
    op(0, 1, 2'b10, 0, 32'h50, 32'h22222222);
    op(1, 0, 2'b10, 0, 32'h4C, 0);

    abort_op(0, 1, 2'b00, 32'h40, 32'h000000EE);
    op(1, 0, 2'b10, 0, 32'h40, 0);
    abort_op(1, 0, 2'b00, 32'h40, 0);
    op(0, 0, 2'b10, 0, 32'h40, 0);

    for (int n = 0; n < 400; n++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        else if (sz[1]) a[1:0] = 2'b00;
      end
      op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
         a, $urandom);
    end

    for (int i = 0; i < 64; i++) op(1, 0, 2'b10, 0, 32'(i * 4), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
